cp0_param: RTL and testbench

Parametrised coprocessor-0 for the MIPS-style core: the CP0 block generalised in external interrupt count, timer rate and interrupt-input synchronisation, plus interrupt index reporting and exception vector generation. It sits beside the writeback/exception stage, takes MTC0/MFC0 accesses and committed exception/ERET events, and drives the pipeline's interrupt request and redirect vector. Registers provided: BadVAddr, Count, Compare, Status, Cause, EPC.

---
 rtl/cp0_param.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cp0_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_param.sv
// cp0_param: parametrised MIPS-style coprocessor 0.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. It serves MTC0 writes
// and combinational MFC0 reads, records committed exceptions and ERETs, runs
// the Count/Compare timer and drives the interrupt request and exception vector.
//
// Parameters
//   N_EXT_INT   : external interrupt lines (1..6), ext_int[i] -> Cause.IP[2+i]
//   TIMER_DIV   : Count increments once every TIMER_DIV clocks (>=1)
//   SYNC_STAGES : synchroniser flops ahead of the IP register (0..3)
//
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   ext_int                : level external interrupts
//   wen, addr, wdata       : MTC0 strobe, {rd,sel} address, write data
//   rdata                  : MFC0 read data (combinational on addr, 0 if unmapped)
//   exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret
//                          : committed exception / ERET event and its details
//   int_req, int_idx       : interrupt request and highest pending IP index
//   exc_vector             : exception entry address (selected by Status.BEV)
//   status, cause, epc     : live register values
module cp0_param #(
    parameter int N_EXT_INT   = 6,
    parameter int TIMER_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_EXT_INT-1:0] ext_int,
    input  logic                 wen,
    input  logic [7:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_excode,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_epc,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 exc_eret,
    output logic                 int_req,
    output logic [2:0]           int_idx,
    output logic [31:0]          exc_vector,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic [31:0]          epc
);

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

    // ------------------------------------------------------------------
    // External interrupt synchroniser
    // ------------------------------------------------------------------
    logic [N_EXT_INT-1:0] ext_sync;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            // The IP register itself provides the single registration stage.
            assign ext_sync = ext_int;
        end else begin : g_sync
            logic [N_EXT_INT-1:0] sync_q [SYNC_STAGES];
            logic [N_EXT_INT-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = ext_int;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign ext_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0]   badvaddr_q, badvaddr_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ti_q, ti_d;
    logic          bev_q, bev_d;
    logic [7:0]    im_q, im_d;
    logic          exl_q, exl_d;
    logic          ie_q, ie_d;
    logic [1:0]    ip_sw_q, ip_sw_d;
    logic [5:0]    ip_hw_q, ip_hw_d;    // Cause.IP[7:2]
    logic          bd_q, bd_d;
    logic [4:0]    excode_q, excode_d;
    logic [31:0]   epc_q, epc_d;

    logic          is_exc, is_eret;
    logic          wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [5:0]    ext_pad;

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        presc_d    = presc_q;
        ti_d       = ti_q;
        bev_d      = bev_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        ip_sw_d    = ip_sw_q;
        bd_d       = bd_q;
        excode_d   = excode_q;
        epc_d      = epc_q;

        is_exc     = exc_valid & ~exc_eret;
        is_eret    = exc_valid & exc_eret;
        wr_count   = wen && (addr == ADDR_COUNT);
        wr_compare = wen && (addr == ADDR_COMPARE);
        wr_status  = wen && (addr == ADDR_STATUS);
        wr_cause   = wen && (addr == ADDR_CAUSE);
        wr_epc     = wen && (addr == ADDR_EPC);

        // Timer: a Count write restarts the prescaler and beats the increment.
        if (wr_count) begin
            presc_d = '0;
            count_d = wdata;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (wr_compare) begin
            compare_d = wdata;
        end

        // TI is sticky; a Compare write clears it even on a match cycle.
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        // Hardware IP bits; TI lands in IP[7] one clock after TI itself.
        ext_pad = '0;
        ext_pad[N_EXT_INT-1:0] = ext_sync;
        ip_hw_d = ext_pad | {ti_q, 5'b0};

        if (wr_status) begin
            bev_d = wdata[22];
            im_d  = wdata[15:8];
            exl_d = wdata[1];
            ie_d  = wdata[0];
        end
        if (wr_cause) begin
            ip_sw_d = wdata[9:8];
        end
        // An exception/ERET in the same cycle owns EPC, so the MTC0 is dropped.
        if (wr_epc && !exc_valid) begin
            epc_d = wdata;
        end

        // Exception events override MTC0 for EXL and the exception record.
        if (is_exc) begin
            exl_d = 1'b1;
            if (!exl_q) begin
                epc_d    = exc_epc;
                bd_d     = exc_bd;
                excode_d = exc_excode;
            end
            if (exc_excode == 5'd4 || exc_excode == 5'd5) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (is_eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            presc_q    <= '0;
            ti_q       <= 1'b0;
            bev_q      <= 1'b1;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            bd_q       <= 1'b0;
            excode_q   <= '0;
            epc_q      <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            presc_q    <= presc_d;
            ti_q       <= ti_d;
            bev_q      <= bev_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            bd_q       <= bd_d;
            excode_q   <= excode_d;
            epc_q      <= epc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [7:0] ip_all;
    logic [7:0] pend;

    always_comb begin
        ip_all = {ip_hw_q, ip_sw_q};
        pend   = ip_all & im_q;

        status = {9'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
        cause  = {bd_q, ti_q, 14'b0, ip_all, 1'b0, excode_q, 2'b0};
        epc    = epc_q;

        exc_vector = bev_q ? 32'hBFC0_0380 : 32'h8000_0180;
        int_req    = (|pend) & ie_q & ~exl_q;

        // Ascending scan so the highest pending bit is the last one kept.
        int_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) begin
                int_idx = 3'(i);
            end
        end
        if (!int_req) begin
            int_idx = 3'd0;
        end

        case (addr)
            ADDR_BADVADDR: rdata = badvaddr_q;
            ADDR_COUNT:    rdata = count_q;
            ADDR_COMPARE:  rdata = compare_q;
            ADDR_STATUS:   rdata = status;
            ADDR_CAUSE:    rdata = cause;
            ADDR_EPC:      rdata = epc_q;
            default:       rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_param.sv
module tb_cp0_param;

    logic        clk;
    logic        resetn;
    logic [5:0]  ext_int;
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_valid;
    logic [4:0]  exc_excode;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic [31:0] exc_badvaddr;
    logic        exc_eret;
    logic        int_req;
    logic [2:0]  int_idx;
    logic [31:0] exc_vector;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    int n_chk  = 0;
    int n_fail = 0;

    cp0_param #(
        .N_EXT_INT   (6),
        .TIMER_DIV   (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ext_int      (ext_int),
        .wen          (wen),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .exc_valid    (exc_valid),
        .exc_excode   (exc_excode),
        .exc_bd       (exc_bd),
        .exc_epc      (exc_epc),
        .exc_badvaddr (exc_badvaddr),
        .exc_eret     (exc_eret),
        .int_req      (int_req),
        .int_idx      (int_idx),
        .exc_vector   (exc_vector),
        .status       (status),
        .cause        (cause),
        .epc          (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wen   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                       input logic [31:0] bad, input logic eret);
        exc_valid    = 1'b1;
        exc_excode   = code;
        exc_bd       = bd;
        exc_epc      = pc;
        exc_badvaddr = bad;
        exc_eret     = eret;
        tick();
        exc_valid    = 1'b0;
        exc_eret     = 1'b0;
    endtask

    logic [31:0] v;
    int          n;

    initial begin
        resetn       = 1'b0;
        ext_int      = '0;
        wen          = 1'b0;
        addr         = 8'h00;
        wdata        = '0;
        exc_valid    = 1'b0;
        exc_excode   = '0;
        exc_bd       = 1'b0;
        exc_epc      = '0;
        exc_badvaddr = '0;
        exc_eret     = 1'b0;
        #12;

        // Reset values
        check_val("rst_status", status, 32'h0040_0000);
        check_val("rst_cause", cause, 32'h0);
        check_val("rst_epc", epc, 32'h0);
        check_val("rst_vector", exc_vector, 32'hBFC0_0380);
        check_val("rst_int_req", {31'b0, int_req}, 32'h0);
        check_val("rst_int_idx", {29'b0, int_idx}, 32'h0);
        rd(8'h48, v);
        check_val("rst_count", v, 32'h0);

        // Release: first Count increment three clocks later; Count==Compare(0)
        // sets TI on the first clock and IP[7] on the second.
        @(negedge clk);
        resetn = 1'b1;
        ticks(2);
        rd(8'h48, v);
        check_val("rel_count_2clk", v, 32'h0);
        tick();
        rd(8'h48, v);
        check_val("rel_count_3clk", v, 32'h1);
        check_val("rel_cause_ti_ip7", cause, 32'h4000_8000);
        check_val("rel_int_req_masked", {31'b0, int_req}, 32'h0);

        mtc0(8'h58, 32'hFFFF_0000);
        check_val("cmp_wr_clears_ti", cause, 32'h0000_8000);
        tick();
        check_val("ip7_follows_ti", cause, 32'h0);

        mtc0(8'h60, 32'h0);
        check_val("status_zero", status, 32'h0);
        check_val("vector_bev0", exc_vector, 32'h8000_0180);

        // Timer wrap with TIMER_DIV=3
        mtc0(8'h48, 32'hFFFF_FFFE);
        ticks(2);
        rd(8'h48, v);
        check_val("count_hold", v, 32'hFFFF_FFFE);
        tick();
        rd(8'h48, v);
        check_val("count_inc", v, 32'hFFFF_FFFF);
        ticks(3);
        rd(8'h48, v);
        check_val("count_wrap", v, 32'h0);

        // Compare=5: Count reaches 5 after 15 clocks, TI seen one clock later
        mtc0(8'h58, 32'h5);
        n = 0;
        while (!cause[30] && n < 40) begin
            tick();
            n++;
        end
        check_val("ti_latency", n, 32'd15);
        rd(8'h48, v);
        check_val("ti_count", v, 32'h5);
        mtc0(8'h58, 32'hFFFF_0000);
        check_val("ti_cleared", {31'b0, cause[30]}, 32'h0);
        tick();

        // External interrupts through two sync stages
        mtc0(8'h60, 32'h0000_8401);
        check_val("int_idle", {31'b0, int_req}, 32'h0);
        ext_int = 6'h01;
        ticks(2);
        check_val("int_req_2clk", {31'b0, int_req}, 32'h0);
        tick();
        check_val("int_req_3clk", {31'b0, int_req}, 32'h1);
        check_val("int_idx_2", {29'b0, int_idx}, 32'd2);
        ext_int = 6'h21;
        ticks(3);
        check_val("int_idx_7", {29'b0, int_idx}, 32'd7);
        check_val("cause_ip7_ip2", cause, 32'h0000_8400);
        ext_int = 6'h01;
        ticks(3);

        // Exception: AdEL in delay slot with a pending interrupt
        exc(5'd4, 1'b1, 32'hBFC0_0100, 32'h0000_1234, 1'b0);
        check_val("exc_int_drop", {31'b0, int_req}, 32'h0);
        check_val("exc_status", status, 32'h0000_8403);
        check_val("exc_epc", epc, 32'hBFC0_0100);
        check_val("exc_cause_ip2", cause, 32'h8000_0410);
        rd(8'h40, v);
        check_val("exc_badvaddr", v, 32'h0000_1234);
        ext_int = 6'h00;
        ticks(3);
        check_val("exc_cause", cause, 32'h8000_0010);

        // Nested exceptions keep EPC/BD/ExcCode; BadVAddr only for AdEL/AdES
        exc(5'd5, 1'b0, 32'h1111_1111, 32'h0000_5678, 1'b0);
        check_val("exc2_epc", epc, 32'hBFC0_0100);
        check_val("exc2_cause", cause, 32'h8000_0010);
        rd(8'h40, v);
        check_val("exc2_badvaddr", v, 32'h0000_5678);
        exc(5'd8, 1'b0, 32'h1111_1111, 32'h0000_9999, 1'b0);
        rd(8'h40, v);
        check_val("exc3_badvaddr_kept", v, 32'h0000_5678);

        exc(5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("eret_status", status, 32'h0000_8401);
        check_val("eret_epc", epc, 32'hBFC0_0100);

        // MTC0 Status with EXL=0 in the same cycle as an exception
        wen          = 1'b1;
        addr         = 8'h60;
        wdata        = 32'h0040_0001;
        exc(5'd0, 1'b0, 32'h2222_2222, 32'h0, 1'b0);
        wen          = 1'b0;
        check_val("same_status", status, 32'h0040_0003);
        check_val("same_epc", epc, 32'h2222_2222);
        check_val("same_cause", cause, 32'h0);
        check_val("same_vector", exc_vector, 32'hBFC0_0380);

        // ERET beats a same-cycle EPC write
        wen          = 1'b1;
        addr         = 8'h70;
        wdata        = 32'h3333_3333;
        exc(5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        wen          = 1'b0;
        check_val("eret_epc_kept", epc, 32'h2222_2222);
        check_val("eret2_status", status, 32'h0040_0001);
        mtc0(8'h70, 32'h4444_4444);
        check_val("epc_write", epc, 32'h4444_4444);

        // Only IP[1:0] of Cause are writable; software interrupt IP[1]
        mtc0(8'h68, 32'hFFFF_FFFF);
        check_val("cause_sw_write", cause, 32'h0000_0300);
        mtc0(8'h60, 32'h0000_0201);
        check_val("sw_int_req", {31'b0, int_req}, 32'h1);
        check_val("sw_int_idx", {29'b0, int_idx}, 32'd1);
        rd(8'h08, v);
        check_val("unmapped_read", v, 32'h0);

        // Asynchronous reset away from any clock edge
        #3;
        resetn = 1'b0;
        #1;
        check_val("arst_status", status, 32'h0040_0000);
        check_val("arst_cause", cause, 32'h0);
        check_val("arst_epc", epc, 32'h0);
        check_val("arst_int_req", {31'b0, int_req}, 32'h0);
        check_val("arst_vector", exc_vector, 32'hBFC0_0380);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
